// File: rtl/branch_res_station.sv
// Branch/jump reservation station: collapsing queue (slot 0 oldest), CDB wakeup,
// oldest-ready issue over a valid/ready handshake.
module branch_res_station #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic [2:0]       disp_funct3,
  input  logic [1:0]       disp_br_jump_sel,
  input  logic [ROB_W-1:0] disp_rob_idx,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic             disp_src1_rdy,
  input  logic [31:0]      disp_src1_v,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             disp_src2_rdy,
  input  logic [31:0]      disp_src2_v,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [31:0]      iss_pc,
  output logic [31:0]      iss_imm,
  output logic [2:0]       iss_funct3,
  output logic [1:0]       iss_br_jump_sel,
  output logic [ROB_W-1:0] iss_rob_idx,
  output logic [31:0]      iss_src1_v,
  output logic [31:0]      iss_src2_v
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [2:0]       funct3;
    logic [1:0]       bj;
    logic [ROB_W-1:0] rob;
    logic [TAG_W-1:0] t1;
    logic             r1;
    logic [31:0]      v1;
    logic [TAG_W-1:0] t2;
    logic             r2;
    logic [31:0]      v2;
  } entry_t;

  entry_t           ent_q   [DEPTH];
  entry_t           ent_d   [DEPTH];
  entry_t           ent_ext [DEPTH+1];
  entry_t           disp_ent;
  entry_t           iss_ent;
  logic [CNT_W-1:0] cnt_q, cnt_d, wr_idx;
  logic [DEPTH-1:0] rdy, sel_oh, at_or_above;
  logic             any_rdy, issue, disp_acc, cdb_hit;

  assign cdb_hit    = cdb_valid && (cdb_tag != '0);
  assign disp_ready = (cnt_q < CNT_W'(DEPTH));
  assign iss_valid  = any_rdy;
  assign issue      = any_rdy && iss_ready && !flush;
  assign disp_acc   = disp_valid && disp_ready && !flush;
  assign wr_idx     = issue ? (cnt_q - CNT_W'(1)) : cnt_q;

  // Oldest-ready select; at_or_above marks slots that collapse on an issue.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    iss_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i]         = ent_q[i].valid && ent_q[i].r1 && ent_q[i].r2;
      sel_oh[i]      = rdy[i] && !seen;
      seen           = seen || rdy[i];
      at_or_above[i] = seen;
      if (sel_oh[i]) iss_ent = ent_q[i];
    end
    any_rdy = seen;
  end

  assign iss_pc          = iss_ent.pc;
  assign iss_imm         = iss_ent.imm;
  assign iss_funct3      = iss_ent.funct3;
  assign iss_br_jump_sel = iss_ent.bj;
  assign iss_rob_idx     = iss_ent.rob;
  assign iss_src1_v      = iss_ent.v1;
  assign iss_src2_v      = iss_ent.v2;

  always_comb begin
    disp_ent        = '0;
    disp_ent.valid  = 1'b1;
    disp_ent.pc     = disp_pc;
    disp_ent.imm    = disp_imm;
    disp_ent.funct3 = disp_funct3;
    disp_ent.bj     = disp_br_jump_sel;
    disp_ent.rob    = disp_rob_idx;
    disp_ent.t1     = disp_src1_tag;
    disp_ent.r1     = disp_src1_rdy;
    disp_ent.v1     = disp_src1_v;
    disp_ent.t2     = disp_src2_tag;
    disp_ent.r2     = disp_src2_rdy;
    disp_ent.v2     = disp_src2_v;
    if (cdb_hit && !disp_src1_rdy && disp_src1_tag == cdb_tag) begin
      disp_ent.r1 = 1'b1;
      disp_ent.v1 = cdb_data;
    end
    if (cdb_hit && !disp_src2_rdy && disp_src2_tag == cdb_tag) begin
      disp_ent.r2 = 1'b1;
      disp_ent.v2 = cdb_data;
    end
  end

  // Shift, then wake, then insert the dispatched op; flush wins over all.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_ext[i] = ent_q[i];
    ent_ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue && at_or_above[i]) ? ent_ext[i+1] : ent_q[i];
      if (ent_d[i].valid && cdb_hit && !ent_d[i].r1 && ent_d[i].t1 == cdb_tag) begin
        ent_d[i].r1 = 1'b1;
        ent_d[i].v1 = cdb_data;
      end
      if (ent_d[i].valid && cdb_hit && !ent_d[i].r2 && ent_d[i].t2 == cdb_tag) begin
        ent_d[i].r2 = 1'b1;
        ent_d[i].v2 = cdb_data;
      end
      if (disp_acc && CNT_W'(i) == wr_idx) ent_d[i] = disp_ent;
      if (flush) ent_d[i].valid = 1'b0;
    end
    cnt_d = flush ? '0 : (cnt_q + CNT_W'(disp_acc) - CNT_W'(issue));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_res_station.sv
// Randomized scoreboard bench for branch_res_station against a queue-based model.
module tb_branch_res_station;
  localparam int DEPTH = 4;

  logic        clk = 0, rst, flush, disp_valid, disp_ready;
  logic [31:0] disp_pc, disp_imm, disp_src1_v, disp_src2_v, cdb_data;
  logic [2:0]  disp_funct3;
  logic [1:0]  disp_br_jump_sel;
  logic [3:0]  disp_rob_idx;
  logic [5:0]  disp_src1_tag, disp_src2_tag, cdb_tag;
  logic        disp_src1_rdy, disp_src2_rdy, cdb_valid, iss_valid, iss_ready;
  logic [31:0] iss_pc, iss_imm, iss_src1_v, iss_src2_v;
  logic [2:0]  iss_funct3;
  logic [1:0]  iss_br_jump_sel;
  logic [3:0]  iss_rob_idx;

  branch_res_station #(.DEPTH(DEPTH), .TAG_W(6), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_funct3(disp_funct3),
    .disp_br_jump_sel(disp_br_jump_sel), .disp_rob_idx(disp_rob_idx),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy), .disp_src1_v(disp_src1_v),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy), .disp_src2_v(disp_src2_v),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_funct3(iss_funct3), .iss_br_jump_sel(iss_br_jump_sel), .iss_rob_idx(iss_rob_idx),
    .iss_src1_v(iss_src1_v), .iss_src2_v(iss_src2_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, imm;
    logic [2:0]  f3;
    logic [1:0]  bj;
    logic [3:0]  rob;
    logic [5:0]  t1, t2;
    logic        r1, r2;
    logic [31:0] v1, v2;
  } op_t;

  op_t  mq[$];
  op_t  exp_q[$];
  logic exp_valid = 0, exp_dr = 1;
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic op_t wake(input op_t o);
    if (cdb_valid && cdb_tag != 0) begin
      if (!o.r1 && o.t1 == cdb_tag) begin o.r1 = 1; o.v1 = cdb_data; end
      if (!o.r2 && o.t2 == cdb_tag) begin o.r2 = 1; o.v2 = cdb_data; end
    end
    return o;
  endfunction

  // Reference model: ordered list of ops; oldest ready op leaves, new ops join at the tail.
  always @(negedge clk) begin : model
    int  idx;
    int  n;
    op_t o;
    #1;
    if (!rst) begin
      mq.delete();
      exp_valid = 0;
      exp_dr    = 1;
    end else begin
      idx = -1;
      for (int i = 0; i < mq.size(); i++)
        if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
      n         = mq.size();
      exp_valid = (idx >= 0);
      exp_dr    = (n < DEPTH);
      if (flush) mq.delete();
      else begin
        if (exp_valid && iss_ready) begin
          exp_q.push_back(mq[idx]);
          mq.delete(idx);
        end
        for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
        if (disp_valid && n < DEPTH) begin
          o = '{disp_pc, disp_imm, disp_funct3, disp_br_jump_sel, disp_rob_idx,
                disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
                disp_src1_v, disp_src2_v};
          mq.push_back(wake(o));
        end
      end
    end
  end

  always @(negedge rst) mq.delete();

  always @(negedge clk) begin : monitor
    op_t e;
    #2;
    if (rst) begin
      chk("iss_valid", {159'b0, iss_valid}, {159'b0, exp_valid});
      chk("disp_ready", {159'b0, disp_ready}, {159'b0, exp_dr});
      if (iss_valid && iss_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 160'd1, 160'd0);
        end else begin
          e = exp_q.pop_front();
          chk("issued_op",
              {iss_pc, iss_imm, iss_funct3, iss_br_jump_sel, iss_rob_idx, iss_src1_v, iss_src2_v},
              {e.pc, e.imm, e.f3, e.bj, e.rob, e.v1, e.v2});
        end
      end
    end
  end

  task automatic idle();
    disp_valid = 0; flush = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0; iss_ready = 1;
    disp_pc = 0; disp_imm = 0; disp_funct3 = 0; disp_br_jump_sel = 0; disp_rob_idx = 0;
    disp_src1_tag = 0; disp_src1_rdy = 0; disp_src1_v = 0;
    disp_src2_tag = 0; disp_src2_rdy = 0; disp_src2_v = 0;
  endtask

  task automatic go();
    @(negedge clk);
    idle();
  endtask

  task automatic dsp(input logic [31:0] pc, input logic [5:0] t1, input logic r1,
                     input logic [31:0] v1, input logic [5:0] t2, input logic r2,
                     input logic [31:0] v2);
    disp_valid = 1; disp_pc = pc; disp_imm = $urandom;
    disp_funct3 = 3'($urandom_range(0, 7)); disp_br_jump_sel = 2'($urandom_range(0, 2));
    disp_rob_idx = 4'($urandom_range(0, 15));
    disp_src1_tag = t1; disp_src1_rdy = r1; disp_src1_v = v1;
    disp_src2_tag = t2; disp_src2_rdy = r2; disp_src2_v = v2;
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_iss"}, {iss_valid, iss_pc, iss_imm, iss_funct3, iss_br_jump_sel, iss_rob_idx,
                         iss_src1_v, iss_src2_v}, 160'd0);
    chk({name, "_disp_ready"}, {159'b0, disp_ready}, 160'd1);
  endtask

  initial begin
    rst = 0;
    idle();
    #7 chk_zero_outputs("reset");
    @(negedge clk); rst = 1;

    // Single ready beq
    go(); dsp(32'h100, 0, 1, 5, 0, 1, 5); disp_imm = 32'h20; disp_funct3 = 0;
    go(); go();

    // Fill with ops waiting on tag 7, refused fifth, then a single wakeup
    for (int k = 0; k < 4; k++) begin go(); dsp(32'h200 + 4 * k, 7, 0, 0, 7, 0, 0); end
    go(); dsp(32'h2f0, 0, 1, 1, 0, 1, 1);
    go(); cdb_valid = 1; cdb_tag = 7; cdb_data = 32'h40;
    repeat (5) go();

    // Younger ready op overtakes an older waiting one
    go(); dsp(32'h300, 3, 0, 0, 0, 1, 1);
    go(); dsp(32'h304, 0, 1, 2, 0, 1, 2);
    go(); go(); cdb_valid = 1; cdb_tag = 3; cdb_data = 32'h33;
    repeat (3) go();

    // Same-cycle dispatch and CDB capture
    go(); dsp(32'h400, 9, 0, 0, 0, 1, 1); cdb_valid = 1; cdb_tag = 9; cdb_data = 32'hABCD;
    go(); go();

    // Full station with issue and dispatch in the same cycle
    for (int k = 0; k < 4; k++) begin go(); iss_ready = 0; dsp(32'h500 + 4 * k, 0, 1, k, 0, 1, k); end
    go(); dsp(32'h5f0, 0, 1, 9, 0, 1, 9);
    go(); iss_ready = 0; dsp(32'h5f4, 0, 1, 8, 0, 1, 8);
    repeat (6) go();

    // Flush dominates dispatch
    go(); iss_ready = 0; dsp(32'h600, 0, 1, 1, 0, 1, 1);
    go(); iss_ready = 0; dsp(32'h604, 0, 1, 1, 0, 1, 1);
    go(); dsp(32'h608, 0, 1, 1, 0, 1, 1); flush = 1;
    go(); go();

    // Asynchronous reset mid-run
    go(); iss_ready = 0; dsp(32'h700, 0, 1, 1, 0, 1, 1);
    go(); iss_ready = 0; dsp(32'h704, 0, 1, 1, 0, 1, 1);
    go(); iss_ready = 0;
    #3 rst = 0;
    #1 chk_zero_outputs("midrun_reset");
    go(); rst = 1;

    for (int c = 0; c < 3000; c++) begin
      logic r1, r2;
      go();
      iss_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6) begin
        r1 = 1'($urandom_range(0, 1));
        r2 = 1'($urandom_range(0, 1));
        dsp($urandom, r1 ? 6'($urandom_range(0, 7)) : 6'($urandom_range(1, 7)), r1, $urandom,
            r2 ? 6'($urandom_range(0, 7)) : 6'($urandom_range(1, 7)), r2, $urandom);
      end
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_tag   = 6'($urandom_range(0, 7));
      cdb_data  = $urandom;
      flush     = ($urandom_range(0, 99) < 3);
    end
    go(); go();
    #3 chk("pending_expected_issues", 160'(exp_q.size()), 160'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
